// File: rtl/key_in_pio_if.sv
// Avalon-MM slave bus bundle for key_in_pio.
//   address     master->slave  word address (4 registers)
//   chipselect  master->slave  slave select
//   write_n     master->slave  active-low write strobe
//   writedata   master->slave  write data
//   readdata    slave->master  combinational read data, zero wait states
//   irq         slave->master  level interrupt, active high
interface key_in_pio_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;
    logic             irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/key_in_pio.sv
// Input PIO: synchronizes and debounces WIDTH asynchronous inputs, exposes the
// filtered level, latches qualifying edges into a sticky W1C capture register
// and drives a maskable level interrupt.
//   clk      system clock, rising edge
//   reset    synchronous, active high
//   in_port  asynchronous external inputs
//   bus      Avalon-MM slave (address/chipselect/write_n/writedata/readdata/irq)
// Register map: 0 DATA (RO), 1 reserved (reads 0), 2 IRQ_MASK (RW), 3 EDGE_CAP (W1C).
module key_in_pio #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    key_in_pio_if.slave      bus
);
    // Counter is at least one bit wide so the bypass build still elaborates.
    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_TC = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q,  cap_d;
    logic [WIDTH-1:0] sync_last;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] w1c;
    logic             wr_en;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign wr_en     = bus.chipselect & ~bus.write_n;

    always_comb begin
        sync_d[0] = in_port;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Count consecutive disagreeing cycles; the filtered level follows only
    // once the disagreement has persisted for DEBOUNCE_CYCLES edges.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (DEBOUNCE_CYCLES == 0) begin
                filt_d[i] = sync_last[i];
            end else if (sync_last[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_TC) begin
                    filt_d[i] = sync_last[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_det =  filt_d & ~filt_q;
            1:       edge_det = ~filt_d &  filt_q;
            default: edge_det =  filt_d ^  filt_q;
        endcase
    end

    // A detected edge overrides a simultaneous W1C on the same bit.
    always_comb begin
        w1c    = (wr_en && bus.address == 2'd3) ? bus.writedata : '0;
        mask_d = (wr_en && bus.address == 2'd2) ? bus.writedata : mask_q;
        cap_d  = (cap_q & ~w1c) | edge_det;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            filt_q <= '0;
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            filt_q <= filt_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
        end
    end

    always_comb begin
        case (bus.address)
            2'd0:    bus.readdata = filt_q;
            2'd2:    bus.readdata = mask_q;
            2'd3:    bus.readdata = cap_q;
            default: bus.readdata = '0;
        endcase
    end

    assign bus.irq = |(cap_q & mask_q);
endmodule

// File: tb/tb_key_in_pio.sv
module tb_key_in_pio;
    localparam int NI   = 4;
    localparam int SYNC = 2;
    localparam int ET_P [NI] = '{0, 1, 2, 0};
    localparam int DB_P [NI] = '{4, 4, 4, 0};

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_port;
    logic [1:0] address;
    logic       cs, wn;
    logic [7:0] wd;
    logic [7:0] rd_w  [NI];
    logic       irq_w [NI];

    int n_pass  = 0;
    int n_total = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        key_in_pio_if #(.WIDTH(8)) bus ();
        assign bus.address    = address;
        assign bus.chipselect = cs;
        assign bus.write_n    = wn;
        assign bus.writedata  = wd;
        assign rd_w[g]        = bus.readdata;
        assign irq_w[g]       = bus.irq;
        key_in_pio #(
            .WIDTH(8), .SYNC_STAGES(SYNC),
            .DEBOUNCE_CYCLES(DB_P[g]), .EDGE_TYPE(ET_P[g])
        ) u_dut (
            .clk(clk), .reset(reset), .in_port(in_port), .bus(bus.slave)
        );
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    // Reference model: sync = input seen SYNC edges ago; filtered level flips
    // once the last D synced samples all disagree with it.
    logic [7:0] in_hist [$];
    logic [7:0] sync_hist [$];
    logic [7:0] m_filt [NI];
    logic [7:0] m_cap  [NI];
    logic [7:0] m_mask [NI];

    initial begin
        for (int g = 0; g < NI; g++) begin
            m_filt[g] = 8'h00; m_cap[g] = 8'h00; m_mask[g] = 8'h00;
        end
    end

    always @(posedge clk) begin
        logic [7:0] s_now, nf, ev, clr;
        bit all_diff;
        if (reset) begin
            in_hist.delete();
            sync_hist.delete();
            for (int g = 0; g < NI; g++) begin
                m_filt[g] = 8'h00; m_cap[g] = 8'h00; m_mask[g] = 8'h00;
            end
        end else begin
            s_now = (in_hist.size() >= SYNC) ? in_hist[SYNC-1] : 8'h00;
            in_hist.push_front(in_port);
            if (in_hist.size() > 8) void'(in_hist.pop_back());
            sync_hist.push_front(s_now);
            if (sync_hist.size() > 8) void'(sync_hist.pop_back());
            clr = (cs && !wn && address == 2'd3) ? wd : 8'h00;
            for (int g = 0; g < NI; g++) begin
                nf = m_filt[g];
                for (int b = 0; b < 8; b++) begin
                    if (DB_P[g] == 0) begin
                        nf[b] = s_now[b];
                    end else if (sync_hist.size() >= DB_P[g]) begin
                        all_diff = 1'b1;
                        for (int k = 0; k < DB_P[g]; k++)
                            if (sync_hist[k][b] == m_filt[g][b]) all_diff = 1'b0;
                        if (all_diff) nf[b] = ~m_filt[g][b];
                    end
                end
                if (ET_P[g] == 0)      ev = nf & ~m_filt[g];
                else if (ET_P[g] == 1) ev = ~nf & m_filt[g];
                else                   ev = nf ^ m_filt[g];
                m_cap[g] = (m_cap[g] & ~clr) | ev;
                if (cs && !wn && address == 2'd2) m_mask[g] = wd;
                m_filt[g] = nf;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp;
        if (check_en) begin
            for (int g = 0; g < NI; g++) begin
                case (address)
                    2'd0:    exp = m_filt[g];
                    2'd2:    exp = m_mask[g];
                    2'd3:    exp = m_cap[g];
                    default: exp = 8'h00;
                endcase
                chk($sformatf("model_rd%0d_a%0d", g, address), rd_w[g], exp);
                chk($sformatf("model_irq%0d", g), irq_w[g], |(m_cap[g] & m_mask[g]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [1:0] a, logic [7:0] d);
        cs = 1'b1; wn = 1'b0; address = a; wd = d;
        tick();
        cs = 1'b0; wn = 1'b1; wd = 8'h00;
    endtask

    task automatic chk_rd(int g, logic [1:0] a, logic [7:0] exp, string nm);
        address = a;
        #1;
        chk($sformatf("%s_i%0d", nm, g), rd_w[g], exp);
    endtask

    initial begin
        cs = 1'b0; wn = 1'b1; address = 2'd0; wd = 8'h00;
        in_port = 8'hFF; reset = 1'b1;
        tick();
        check_en = 1'b1;

        // Reset: every register reads 0, irq low, even with inputs high.
        for (int a = 0; a < 4; a++) begin
            for (int g = 0; g < NI; g++) begin
                chk_rd(g, 2'(a), 8'h00, "rst_rd");
                chk($sformatf("rst_irq_i%0d", g), irq_w[g], 1'b0);
            end
            tick();
        end
        reset = 1'b0;
        address = 2'd0;
        repeat (5) tick();
        chk_rd(0, 2'd0, 8'h00, "rst_hold");
        tick();
        chk_rd(0, 2'd0, 8'hFF, "rst_lat");
        chk_rd(0, 2'd3, 8'hFF, "rst_cap");
        wr(2'd3, 8'hFF);

        // Latency 0 -> 01: visible at N+5, not N+4.
        in_port = 8'h00;
        repeat (8) tick();
        wr(2'd3, 8'hFF);
        chk_rd(0, 2'd3, 8'h00, "t2_clr");
        in_port = 8'h01;
        repeat (5) tick();
        chk_rd(0, 2'd0, 8'h00, "t2_data_n4");
        chk_rd(0, 2'd3, 8'h00, "t2_cap_n4");
        tick();
        chk_rd(0, 2'd0, 8'h01, "t2_data_n5");
        chk_rd(0, 2'd3, 8'h01, "t2_cap_n5");

        // Bounce on bit3: 3-cycle pulses never qualify.
        for (int p = 0; p < 4; p++) begin
            in_port = (p % 2 == 0) ? 8'h09 : 8'h01;
            repeat (3) begin
                tick();
                chk_rd(0, 2'd0, 8'h01, "t3_bounce_data");
            end
        end
        in_port = 8'h09;
        repeat (5) begin
            tick();
            chk_rd(0, 2'd3, 8'h01, "t3_bounce_cap");
        end
        tick();
        chk_rd(0, 2'd0, 8'h09, "t3_data");
        chk_rd(0, 2'd3, 8'h09, "t3_cap");

        // IRQ masking and W1C clear.
        wr(2'd3, 8'hFF);
        wr(2'd2, 8'h01);
        in_port = 8'h08;
        repeat (8) tick();
        wr(2'd3, 8'hFF);
        chk("t4_irq_idle", irq_w[0], 1'b0);
        in_port = 8'h09;
        repeat (6) tick();
        chk("t4_irq_set", irq_w[0], 1'b1);
        chk_rd(0, 2'd3, 8'h01, "t4_cap0");
        wr(2'd3, 8'h01);
        chk("t4_irq_clr", irq_w[0], 1'b0);
        in_port = 8'h0B;
        repeat (6) tick();
        chk_rd(0, 2'd3, 8'h02, "t4_cap1");
        chk("t4_irq_masked", irq_w[0], 1'b0);

        // Edge on bit2 lands together with W1C of bits 2 and 5.
        wr(2'd3, 8'hFF);
        in_port = 8'h2B;
        repeat (6) tick();
        chk_rd(0, 2'd3, 8'h20, "t5_cap5");
        in_port = 8'h2F;
        repeat (5) tick();
        wr(2'd3, 8'h24);
        chk_rd(0, 2'd3, 8'h04, "t5_collide");

        // Falling-only and any-edge instances; DATA ignores writes.
        wr(2'd3, 8'hFF);
        in_port = 8'h6F;
        repeat (6) tick();
        chk_rd(1, 2'd3, 8'h00, "t6_fall_rise");
        chk_rd(2, 2'd3, 8'h40, "t6_any_rise");
        wr(2'd3, 8'hFF);
        in_port = 8'h2F;
        repeat (6) tick();
        chk_rd(1, 2'd3, 8'h40, "t6_fall_fall");
        chk_rd(2, 2'd3, 8'h40, "t6_any_fall");
        wr(2'd0, 8'h00);
        chk_rd(0, 2'd0, 8'h2F, "t6_data_ro");
        chk_rd(3, 2'd0, 8'h2F, "t6_data_bypass");

        // Randomized traffic, including occasional mid-debounce resets.
        repeat (3000) begin
            if ($urandom_range(0, 5) == 0)
                in_port = in_port ^ (8'h01 << $urandom_range(0, 7));
            cs      = ($urandom_range(0, 3) == 0);
            wn      = 1'($urandom_range(0, 1));
            address = 2'($urandom_range(0, 3));
            wd      = 8'($urandom);
            reset   = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; cs = 1'b0; wn = 1'b1;
        tick();
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
